board_vram_write_ctrl: RTL and testbench
========================================

// Module: board_vram_write_ctrl
// PURPOSE
//  Sole owner of the write port of the 14x14x6-bit board VRAM. The display path only reads.
//  Two requesters share the port:
//   - game logic: single-cell writes using a valid/ready handshake;
//   - built-in clear engine: fills every cell with one value.
//  Converts (x,y) board coordinates into a linear RAM address. Sequences the clear sweep.
// PARAMETERS
//  COLS  14  board columns
//  ROWS  14  board rows
//  DW    6   cell data width
//  AW    8   RAM address width; COLS*ROWS must be <= 2**AW
// PORTS
//  clk             in   1   system clock (VGA pixel domain)
//  rst_n           in   1   async reset, active-low
//  wr_valid        in   1   game-logic write request
//  wr_ready        out  1   request accepted this cycle when wr_valid & wr_ready
//  wr_x            in   4   column 0..COLS-1
//  wr_y            in   4   row 0..ROWS-1
//  wr_data         in   DW  cell value
//  clr_start       in   1   one-cycle pulse; starts a full-board fill
//  clr_value       in   DW  fill value, sampled on the accepted clr_start
//  clr_busy        out  1   high while the sweep runs
//  clr_done        out  1   one-cycle pulse when the sweep completes
//  err_range       out  1   one-cycle pulse: an accepted write had out-of-range coordinates
//  vblank          in   1   vertical blanking indicator (used only with the option)
//  vram_wraddress  out  AW  to RAM wraddress
//  vram_data       out  DW  to RAM data
//  vram_wren       out  1   to RAM wren
// BEHAVIOUR
//  - Reset values: all outputs 0; FSM in IDLE; clear counter 0.
//    wr_ready first rises in the cycle after rst_n deasserts.
//  - FSM has two states: IDLE and CLEAR.
//    IDLE -> CLEAR on clr_start. CLEAR -> IDLE after the write to address COLS*ROWS-1.
//  - wr_ready = (state==IDLE) & ~clr_start [& gate]. It is low throughout CLEAR.
//    clr_start and wr_valid in the same cycle: clear wins; the write is not accepted.
//  - clr_start during CLEAR is ignored. The sweep does not restart and clr_value is not resampled.
//  - Accepted write: address = wr_y*COLS + wr_x, computed as (y<<4)-(y<<1)+x for COLS=14.
//    vram_* outputs are registered: wren=1 with that address/data exactly one cycle after acceptance.
//    Back-to-back accepted writes give one wren per cycle.
//  - Out-of-range write (wr_x>=COLS or wr_y>=ROWS): handshake still completes.
//    No wren is issued; err_range pulses one cycle after acceptance.
//  - CLEAR: one write per cycle, addresses 0,1,...,COLS*ROWS-1 (0..195), data = latched clr_value.
//    clr_busy is high from the cycle after clr_start through the cycle of the last wren.
//    clr_done pulses in the cycle after the last wren; wr_ready returns high in that same cycle.
//  - Reset mid-sweep: sweep aborts, wren drops immediately, no clr_done. Remaining cells keep old contents.
//  - vram_wren is 0 in any cycle with no pending write; address/data hold their last value.
// CONFIGURATION
//  VGA_VBLANK_WRITE_EN defined:
//   - every RAM write, from either source, is allowed only while vblank=1.
//   - wr_ready includes "& vblank" as its gate term.
//   - CLEAR pauses while vblank=0: no wren, counter holds, clr_busy stays high.
//     It resumes at the same address when vblank returns to 1.
//     A full 196-cycle sweep may span several blanking intervals.
//  Not defined: vblank is ignored; writes proceed at any time; gate term is 1.
// TESTING
//  T1 reset: hold rst_n=0 while driving wr_valid=1 -> wren=0, wr_ready=0, clr_busy=0.
//     Release rst_n -> wr_ready=1 next cycle.
//  T2 single write: x=3,y=2,data=6'h15 -> one cycle later wren=1, wraddress=31, data=6'h15, for one cycle.
//  T3 corners: (0,0)->0; (13,13)->195; x=14,y=0 -> no wren, err_range pulse; x=0,y=15 -> same.
//  T4 clear: clr_start with clr_value=6'h3F -> 196 consecutive wrens, addresses 0..195.
//     clr_done one cycle after address 195; wr_ready=0 throughout.
//  T5 collision: clr_start and wr_valid together -> write not accepted; it is accepted after clr_done.
//     clr_start pulsed mid-sweep -> total wren count stays 196.
//  T6 abort/option: rst_n low at address 100 -> wren drops, no clr_done.
//     With VGA_VBLANK_WRITE_EN: vblank low 50 cycles mid-sweep -> counter holds, resumes at same address.

Source files
------------

// File: rtl/board_vram_write_ctrl.sv
// Single writer for the 14x14x6 board VRAM: arbitrates game-logic cell writes and a full-board clear sweep.
// Latency: 1 cycle from accepted write (or sweep step) to vram_wren; sweep is COLS*ROWS cycles plus a done cycle.
// Backpressure: wr_ready low during the sweep and on a clr_start cycle; optional VGA_VBLANK_WRITE_EN gates all writes on vblank.
module board_vram_write_ctrl #(
    parameter int COLS = 14,
    parameter int ROWS = 14,
    parameter int DW   = 6,
    parameter int AW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [3:0]    wr_x,
    input  logic [3:0]    wr_y,
    input  logic [DW-1:0] wr_data,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_value,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          err_range,
    input  logic          vblank,
    output logic [AW-1:0] vram_wraddress,
    output logic [DW-1:0] vram_data,
    output logic          vram_wren
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW-1:0] LAST   = AW'(COLS * ROWS - 1);
    localparam logic [AW-1:0] COLS_A = AW'(COLS);

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [DW-1:0] clr_val;
    logic          sweep_end;
    logic          ready_en;
    logic          gate;
    logic          wr_acc;
    logic          in_range;
    logic [AW-1:0] x_ext;
    logic [AW-1:0] y_ext;
    logic [AW-1:0] lin_addr;

`ifdef VGA_VBLANK_WRITE_EN
    assign gate = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign gate          = 1'b1;
`endif

    // ready_en keeps wr_ready low during reset and rises on the first clock after release
    assign wr_ready = ready_en & (state == IDLE) & ~clr_start & gate;
    assign wr_acc   = wr_valid & wr_ready;
    assign in_range = (32'(wr_x) < COLS) && (32'(wr_y) < ROWS);
    assign x_ext    = AW'(wr_x);
    assign y_ext    = AW'(wr_y);

    generate
        if (COLS == 14) begin : g_addr_shift
            assign lin_addr = (y_ext << 4) - (y_ext << 1) + x_ext;
        end else begin : g_addr_mul
            assign lin_addr = y_ext * COLS_A + x_ext;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            clr_cnt        <= '0;
            clr_val        <= '0;
            sweep_end      <= 1'b0;
            ready_en       <= 1'b0;
            clr_busy       <= 1'b0;
            clr_done       <= 1'b0;
            err_range      <= 1'b0;
            vram_wraddress <= '0;
            vram_data      <= '0;
            vram_wren      <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            vram_wren <= 1'b0;
            err_range <= 1'b0;
            clr_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state     <= CLEAR;
                        clr_val   <= clr_value;
                        clr_cnt   <= '0;
                        sweep_end <= 1'b0;
                        clr_busy  <= 1'b1;
                    end else if (wr_acc) begin
                        if (in_range) begin
                            vram_wren      <= 1'b1;
                            vram_wraddress <= lin_addr;
                            vram_data      <= wr_data;
                        end else begin
                            err_range <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    // sweep_end marks the cycle showing the last wren; done follows one cycle later
                    if (sweep_end) begin
                        state     <= IDLE;
                        clr_busy  <= 1'b0;
                        clr_done  <= 1'b1;
                        sweep_end <= 1'b0;
                        clr_cnt   <= '0;
                    end else if (gate) begin
                        vram_wren      <= 1'b1;
                        vram_wraddress <= clr_cnt;
                        vram_data      <= clr_val;
                        if (clr_cnt == LAST) sweep_end <= 1'b1;
                        else                 clr_cnt   <= clr_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_vram_write_ctrl.sv
// Self-checking bench for board_vram_write_ctrl: scoreboard of expected RAM writes checked by a wren monitor.
module tb_board_vram_write_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [3:0] wr_x = '0;
    logic [3:0] wr_y = '0;
    logic [5:0] wr_data = '0;
    logic       clr_start = 1'b0;
    logic [5:0] clr_value = '0;
    logic       clr_busy;
    logic       clr_done;
    logic       err_range;
    logic       vblank = 1'b1;
    logic [7:0] vram_wraddress;
    logic [5:0] vram_data;
    logic       vram_wren;

    typedef struct {
        logic [7:0] a;
        logic [5:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    board_vram_write_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .clr_start(clr_start),
        .clr_value(clr_value), .clr_busy(clr_busy), .clr_done(clr_done),
        .err_range(err_range), .vblank(vblank), .vram_wraddress(vram_wraddress),
        .vram_data(vram_data), .vram_wren(vram_wren)
    );

    // every wren seen must match the oldest expected write
    always @(negedge clk) begin
        exp_t e;
        if (vram_wren) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wren addr=%0d data=%h required no write", vram_wraddress, vram_data);
            end else begin
                e = sb.pop_front();
                if (vram_wraddress !== e.a || vram_data !== e.d) begin
                    errors++;
                    $display("FAIL wr_cmp got addr=%0d data=%h required addr=%0d data=%h",
                             vram_wraddress, vram_data, e.a, e.d);
                end
            end
        end
    end

    task automatic push_clear(input logic [5:0] v, input int n);
        exp_t e;
        for (int a = 0; a < n; a++) begin
            e.a = 8'(a);
            e.d = v;
            sb.push_back(e);
        end
    endtask

    task automatic drive_write(input logic [3:0] x, input logic [3:0] y, input logic [5:0] d, output logic rdy);
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_x = x; wr_y = y; wr_data = d;
        @(negedge clk);
        rdy = wr_ready;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; wr_valid = 1'b1; wr_x = 4'd1; wr_y = 4'd1;
        repeat (3) @(negedge clk);
        checks++;
        if (vram_wren !== 1'b0 || wr_ready !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0 || err_range !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs wren=%b rdy=%b busy=%b done=%b err=%b required all 0",
                     vram_wren, wr_ready, clr_busy, clr_done, err_range);
        end
        wr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_release_cycle got %b required 0", wr_ready);
        end
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got %b required 1", wr_ready);
        end
    endtask

    task automatic test_single;
        exp_t e;
        logic rdy;
        e.a = 8'd31; e.d = 6'h15;
        sb.push_back(e);
        drive_write(4'd3, 4'd2, 6'h15, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL single_ready got %b required 1", rdy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_pending got %0d writes outstanding required 0", sb.size());
        end
    endtask

    task automatic test_corners;
        logic [3:0] xs[4] = '{4'd0, 4'd13, 4'd14, 4'd0};
        logic [3:0] ys[4] = '{4'd0, 4'd13, 4'd0, 4'd15};
        exp_t e;
        logic rdy, bad;
        for (int i = 0; i < 4; i++) begin
            bad = (xs[i] >= 4'd14) || (ys[i] >= 4'd14);
            if (!bad) begin
                e.a = 8'(int'(ys[i]) * 14 + int'(xs[i]));
                e.d = 6'(i + 8);
                sb.push_back(e);
            end
            drive_write(xs[i], ys[i], 6'(i + 8), rdy);
            @(negedge clk);
            checks++;
            if (rdy !== 1'b1 || err_range !== bad) begin
                errors++;
                $display("FAIL corner_%0d rdy=%b err=%b required rdy=1 err=%b", i, rdy, err_range, bad);
            end
            @(negedge clk);
            checks++;
            if (err_range !== 1'b0) begin
                errors++;
                $display("FAIL corner_%0d_err_pulse got %b required 0", i, err_range);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL corner_pending got %0d required 0", sb.size());
        end
    endtask

    task automatic test_clear;
        int first = -1, last = -1, done_i = -1, nw = 0, rdy_bad = 0, busy_bad = 0;
        logic rdy_done = 1'b0, busy_done = 1'b1, busy0 = 1'b0;
        push_clear(6'h3F, 196);
        @(posedge clk); #1;
        clr_start = 1'b1; clr_value = 6'h3F;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_start_ready got %b required 0", wr_ready);
        end
        @(posedge clk); #1;
        clr_start = 1'b0; clr_value = 6'h00;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == 0) busy0 = clr_busy;
            if (vram_wren) begin
                nw++;
                if (first < 0) first = i;
                last = i;
                if (!clr_busy) busy_bad++;
            end
            if (clr_done) begin
                done_i = i; rdy_done = wr_ready; busy_done = clr_busy;
                break;
            end
            if (wr_ready) rdy_bad++;
        end
        checks++;
        if (done_i < 0 || nw != 196 || last - first != 195 || done_i != last + 1) begin
            errors++;
            $display("FAIL clear_sweep done_at=%0d wrens=%0d span=%0d last=%0d required wrens=196 span=195 done=last+1",
                     done_i, nw, last - first, last);
        end
        checks++;
        if (busy0 !== 1'b1 || busy_bad != 0 || busy_done !== 1'b0) begin
            errors++;
            $display("FAIL clear_busy first=%b gaps=%0d at_done=%b required 1,0,0", busy0, busy_bad, busy_done);
        end
        checks++;
        if (rdy_bad != 0 || rdy_done !== 1'b1) begin
            errors++;
            $display("FAIL clear_ready high_during=%0d at_done=%b required 0,1", rdy_bad, rdy_done);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL clear_pending got %0d required 0", sb.size());
        end
    endtask

    task automatic test_collision;
        exp_t e;
        int got = -1;
        logic done_seen = 1'b0;
        push_clear(6'h01, 196);
        e.a = 8'd19; e.d = 6'h0A;
        sb.push_back(e);
        @(posedge clk); #1;
        clr_start = 1'b1; clr_value = 6'h01;
        wr_valid = 1'b1; wr_x = 4'd5; wr_y = 4'd1; wr_data = 6'h0A;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL collision_ready got %b required 0", wr_ready);
        end
        @(posedge clk); #1;
        clr_start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == 50) begin clr_start = 1'b1; clr_value = 6'h2A; end
            if (i == 51) clr_start = 1'b0;
            if (wr_ready) begin
                got = i; done_seen = clr_done;
                break;
            end
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        checks++;
        if (got < 0 || done_seen !== 1'b1) begin
            errors++;
            $display("FAIL collision_accept ready_at=%0d done=%b required ready with clr_done=1", got, done_seen);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL collision_pending got %0d required 0", sb.size());
        end
    endtask

    task automatic test_abort;
        logic found = 1'b0;
        int done_cnt = 0;
        push_clear(6'h11, 100);
        @(posedge clk); #1;
        clr_start = 1'b1; clr_value = 6'h11;
        @(posedge clk); #1;
        clr_start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (vram_wren && vram_wraddress == 8'd100) begin found = 1'b1; break; end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (!found || vram_wren !== 1'b0 || clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop found=%b wren=%b busy=%b required found=1 wren=0 busy=0", found, vram_wren, clr_busy);
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (clr_done) done_cnt++;
        end
        checks++;
        if (done_cnt != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL abort_after dones=%0d pending=%0d required 0,0", done_cnt, sb.size());
        end
    endtask

`ifdef VGA_VBLANK_WRITE_EN
    task automatic test_vblank;
        int bad = 0, done_i = -1;
        push_clear(6'h22, 196);
        @(posedge clk); #1;
        clr_start = 1'b1; clr_value = 6'h22;
        @(posedge clk); #1;
        clr_start = 1'b0;
        repeat (60) @(posedge clk);
        #1 vblank = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i > 0 && (vram_wren || !clr_busy || wr_ready)) bad++;
        end
        vblank = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (clr_done) begin done_i = i; break; end
        end
        checks++;
        if (bad != 0 || done_i < 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL vblank_pause violations=%0d done_at=%0d pending=%0d required 0,>=0,0", bad, done_i, sb.size());
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_corners;
        test_clear;
        test_collision;
        test_abort;
`ifdef VGA_VBLANK_WRITE_EN
        test_vblank;
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
